// File: rtl/fetch_pkg.sv
// Shared types and constants for the DLX instruction fetch unit.
package fetch_pkg;

    localparam int FETCH_WORD_SIZE    = 32;
    localparam int FETCH_ADDRESS_SIZE = 16;
    localparam int INSTR_BYTES        = FETCH_WORD_SIZE / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_WORD_SIZE-1:0]    word;
        logic [FETCH_ADDRESS_SIZE-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: registered storage with flush, full/empty flags and a free-slot count.
module fetch_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] free_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      used_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Occupancy from the extra-bit pointers; a flush overrides any push or pop.
    always_comb begin
        used_s     = wr_ptr_r - rd_ptr_r;
        empty      = (used_s == PW'(0));
        full       = (used_s == PW'(DEPTH));
        free_count = PW'(DEPTH) - used_s;
        do_pop_s   = pop && !empty && !flush;
        do_push_s  = push && (!full || do_pop_s) && !flush;
    end

    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
        end else if (flush) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Entry storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// DLX instruction fetch: drives the instruction memory, buffers words and hands them to decode.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int WORD_SIZE      = 32,
    parameter int ADDRESS_SIZE   = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int RESET_PC       = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    mem_enable,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    input  logic [WORD_SIZE-1:0]    mem_data,
    input  logic                    mem_data_ready,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_SIZE-1:0] redirect_pc,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [WORD_SIZE-1:0]    instr_data,
    output logic [ADDRESS_SIZE-1:0] instr_pc,
    output logic                    fetch_error
);
    localparam int EW = WORD_SIZE + ADDRESS_SIZE;
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDRESS_SIZE-1:0] PC_RESET = ADDRESS_SIZE'(RESET_PC);
    localparam logic [ADDRESS_SIZE-1:0] PC_STEP  = ADDRESS_SIZE'(WORD_SIZE / 8);
    localparam logic [TW-1:0]           TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    fetch_state_t            state_r;
    logic [ADDRESS_SIZE-1:0] pc_r;
    logic [TW-1:0]           tmo_cnt_r;
    logic                    fetch_error_r;
    logic                    mem_enable_r;
    logic                    push_s;
    logic                    pop_s;
    logic                    can_fetch_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [FW-1:0]           free_count_s;
    logic [EW-1:0]           head_s;

    // Handshake decode; a redirect cancels both the pop and any response in flight.
    always_comb begin
        pop_s       = !fifo_empty_s && instr_ready && !redirect_valid;
        push_s      = (state_r == REQ) && mem_data_ready && !redirect_valid &&
                      (!fifo_full_s || pop_s);
        can_fetch_s = (free_count_s != FW'(0)) && !fetch_error_r;
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (redirect_valid),
        .wr_data    ({mem_data, pc_r}),
        .rd_data    (head_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .free_count (free_count_s)
    );

    // Fetch FSM; GAP keeps ENABLE low for one cycle so a stale DATA_READY is never sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            pc_r          <= PC_RESET;
            tmo_cnt_r     <= TW'(0);
            fetch_error_r <= 1'b0;
            mem_enable_r  <= 1'b0;
        end else if (redirect_valid) begin
            pc_r          <= redirect_pc;
            tmo_cnt_r     <= TW'(0);
            fetch_error_r <= 1'b0;
            mem_enable_r  <= 1'b0;
            state_r       <= (state_r == REQ) ? GAP : IDLE;
        end else begin
            case (state_r)
                IDLE, GAP: begin
                    if (can_fetch_s) begin
                        state_r      <= REQ;
                        mem_enable_r <= 1'b1;
                    end else begin
                        state_r      <= IDLE;
                        mem_enable_r <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem_data_ready) begin
                        pc_r         <= pc_r + PC_STEP;
                        tmo_cnt_r    <= TW'(0);
                        state_r      <= GAP;
                        mem_enable_r <= 1'b0;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        fetch_error_r <= 1'b1;
                        tmo_cnt_r     <= TW'(0);
                        state_r       <= IDLE;
                        mem_enable_r  <= 1'b0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    mem_enable_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_enable  = mem_enable_r;
    assign mem_address = pc_r;
    assign fetch_error = fetch_error_r;
    assign instr_valid = !fifo_empty_s;
    assign instr_data  = head_s[EW-1:ADDRESS_SIZE];
    assign instr_pc    = head_s[ADDRESS_SIZE-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, corner-case sequences and a random run.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_enable;
    logic [15:0] mem_address;
    logic [31:0] mem_data = 32'hDEAD_BEEF;
    logic        mem_data_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [15:0] instr_pc;
    logic        fetch_error;

    int n_pass  = 0;
    int n_total = 0;
    int mem_cnt = 0;
    int mem_lat = 1;
    int mem_words = 0;
    bit mem_hang = 1'b0;
    bit mem_rand = 1'b0;

    typedef struct {
        logic        rdy;
        logic        en;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] ipc;
    } vec_t;
    vec_t vecs [9];

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .mem_enable     (mem_enable),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .mem_data_ready (mem_data_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .fetch_error    (fetch_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [15:0] a);
        return {~a, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Memory: responds mem_lat cycles after it first sees ENABLE, drops DATA_READY when ENABLE drops.
    task automatic mem_step();
        if (!mem_enable) begin
            mem_cnt        = 0;
            mem_data_ready = 1'b0;
            mem_data       = 32'hDEAD_BEEF;
            if (mem_rand) mem_lat = 1 + int'($urandom_range(2));
        end else begin
            mem_cnt++;
            if (!mem_hang && mem_cnt > mem_lat) begin
                mem_data_ready = 1'b1;
                mem_data       = word_of(mem_address);
                mem_words++;
            end else begin
                mem_data_ready = 1'b0;
                mem_data       = 32'hDEAD_BEEF;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mem_step();
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        instr_ready    = 1'b0;
        mem_data_ready = 1'b0;
        mem_cnt        = 0;
        mem_words      = 0;
        mem_hang       = 1'b0;
        mem_rand       = 1'b0;
        mem_lat        = 1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_en(input string name, input logic [15:0] exp_addr);
        for (int i = 0; i < 40 && !mem_enable; i++) tick();
        chk({name, "_started"}, mem_enable, 1);
        chk({name, "_addr"}, mem_address, exp_addr);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40 && !instr_valid; i++) tick();
        chk({name, "_valid"}, instr_valid, 1);
    endtask

    initial begin
        logic [15:0] exp_pc;
        logic [15:0] prev_addr;
        bit          prev_en, prev_rdy, prev_redir, got;
        int          n, n_acc;
        logic [15:0] resume;

        // cycle-by-cycle expectations after reset, memory latency 1, decode always ready
        vecs[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[1] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0004, 1'b1, 16'h0000};
        vecs[3] = '{1'b1, 1'b1, 16'h0004, 1'b0, 16'h0000};
        vecs[4] = '{1'b1, 1'b1, 16'h0004, 1'b0, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 16'h0008, 1'b1, 16'h0004};
        vecs[6] = '{1'b1, 1'b1, 16'h0008, 1'b0, 16'h0000};
        vecs[7] = '{1'b1, 1'b1, 16'h0008, 1'b0, 16'h0000};
        vecs[8] = '{1'b1, 1'b0, 16'h000C, 1'b1, 16'h0008};

        do_reset();
        chk("rst_mem_enable", mem_enable, 0);
        chk("rst_mem_address", mem_address, 16'h0000);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr_data", instr_data, 32'h0000_0000);
        chk("rst_instr_pc", instr_pc, 16'h0000);
        chk("rst_fetch_error", fetch_error, 0);
        instr_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("vec%0d_enable", i), mem_enable, vecs[i].en);
            chk($sformatf("vec%0d_addr", i), mem_address, vecs[i].addr);
            chk($sformatf("vec%0d_valid", i), instr_valid, vecs[i].vld);
            if (vecs[i].vld) begin
                chk($sformatf("vec%0d_pc", i), instr_pc, vecs[i].ipc);
                chk($sformatf("vec%0d_data", i), instr_data, word_of(vecs[i].ipc));
            end
            instr_ready = vecs[i].rdy;
        end

        // buffer fills to depth, then drains in order and fetching resumes
        do_reset();
        repeat (30) tick();
        chk("fill_words", mem_words, 4);
        chk("fill_enable_idle", mem_enable, 0);
        chk("fill_valid", instr_valid, 1);
        instr_ready = 1'b1;
        n = 0;
        got = 1'b0;
        resume = 16'h0000;
        for (int i = 0; i < 40 && n < 5; i++) begin
            if (mem_enable && !got) begin
                got = 1'b1;
                resume = mem_address;
            end
            if (instr_valid) begin
                chk("drain_pc", instr_pc, 16'(n * 4));
                chk("drain_data", instr_data, word_of(16'(n * 4)));
                n++;
            end
            tick();
        end
        chk("drain_count", n, 5);
        chk("resume_started", got, 1);
        chk("resume_addr", resume, 16'h0010);

        // redirect in REQ with two words buffered and a response arriving the same cycle
        do_reset();
        for (int i = 0; i < 40 && !(mem_words == 3 && mem_data_ready); i++) tick();
        chk("redir_setup_valid", instr_valid, 1);
        chk("redir_setup_enable", mem_enable, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        instr_ready    = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("redir_flush_valid", instr_valid, 0);
        chk("redir_enable_drop", mem_enable, 0);
        wait_en("redir_next", 16'h0100);
        wait_valid("redir_first");
        chk("redir_first_pc", instr_pc, 16'h0100);
        chk("redir_first_data", instr_data, word_of(16'h0100));

        // memory never answers: timeout after 16 request cycles, cleared by redirect
        do_reset();
        mem_hang = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && !fetch_error; i++) begin
            tick();
            if (mem_enable) n++;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_flag", fetch_error, 1);
        chk("timeout_enable_low", mem_enable, 0);
        repeat (5) tick();
        chk("timeout_stays_idle", mem_enable, 0);
        chk("timeout_sticky", fetch_error, 1);
        mem_hang       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        chk("redirect_clears_error", fetch_error, 0);
        wait_en("timeout_restart", 16'h0040);

        // address wrap at the top of memory
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFC;
        tick();
        redirect_valid = 1'b0;
        wait_en("wrap_first", 16'hFFFC);
        for (int i = 0; i < 10 && mem_enable; i++) tick();
        wait_en("wrap_next", 16'h0000);

        // reset asserted mid-request with a response present
        do_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 40 && !(instr_valid && mem_data_ready); i++) tick();
        chk("midrst_setup_pc", instr_pc, 16'h0200);
        rst = 1'b0;
        #1;
        chk("midrst_enable", mem_enable, 0);
        chk("midrst_addr", mem_address, 16'h0000);
        chk("midrst_valid", instr_valid, 0);
        chk("midrst_data", instr_data, 32'h0000_0000);
        chk("midrst_pc", instr_pc, 16'h0000);
        chk("midrst_error", fetch_error, 0);
        mem_data_ready = 1'b0;
        mem_cnt        = 0;
        repeat (2) @(negedge clk);
        rst         = 1'b1;
        instr_ready = 1'b1;
        wait_en("midrst_restart", 16'h0000);
        wait_valid("midrst_first");
        chk("midrst_first_pc", instr_pc, 16'h0000);

        // random run against an in-order stream model
        do_reset();
        mem_rand    = 1'b1;
        instr_ready = 1'b1;
        exp_pc      = 16'h0000;
        n_acc       = 0;
        prev_en     = 1'b0;
        prev_rdy    = 1'b0;
        prev_redir  = 1'b0;
        prev_addr   = 16'h0000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (prev_en && mem_enable) chk("rand_addr_stable", mem_address, prev_addr);
            if (prev_en && (prev_rdy || prev_redir)) chk("rand_gap", mem_enable, 0);
            if (prev_redir) chk("rand_flush", instr_valid, 0);
            instr_ready    = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(59) == 0);
            if (redirect_valid)
                redirect_pc = ($urandom_range(7) == 0) ? 16'hFFF8 : (16'($urandom) & 16'hFFFC);
            if (redirect_valid) begin
                exp_pc = redirect_pc;
            end else if (instr_valid && instr_ready) begin
                chk("rand_pc", instr_pc, exp_pc);
                chk("rand_data", instr_data, word_of(exp_pc));
                exp_pc = exp_pc + 16'd4;
                n_acc++;
            end
            prev_en    = mem_enable;
            prev_addr  = mem_address;
            prev_rdy   = mem_data_ready;
            prev_redir = redirect_valid;
        end
        redirect_valid = 1'b0;
        chk("rand_progress", (n_acc > 150), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
